seg_line_sched: RTL
===================

SEG_LINE_SCHED -- requirements
Module: seg_line_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit, reset, synchronous, active-low.
REQ-003 SHALL have port line_start, input, 1 bit, one-cycle pulse at start of horizontal blanking.
REQ-004 SHALL have port next_y, input, 11 bits, row about to be drawn, sampled on line_start.
REQ-005 SHALL have ports snakepos_x and snakepos_y, input, 253 bits each, segment i coordinate at bits [11*i +: 11]; segment 0 is the head.
REQ-006 SHALL have port length, input, 6 bits, number of live segments.
REQ-007 SHALL have port curr_x, input, 11 bits, pixel column query.
REQ-008 SHALL have port scan_done, output, 1 bit, one-cycle pulse when the list is ready.
REQ-009 SHALL have port hit, output, 1 bit, queried pixel lies in a listed segment.
REQ-010 SHALL have port hit_head, output, 1 bit, winning segment is segment 0.
REQ-011 SHALL have port sprite_addr, output, 10 bits, 32x32 sprite ROM address of the queried pixel.
REQ-012 SHALL have port ovf, output, 1 bit, sticky: more than LIST_DEPTH segments overlapped the current line.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN and READY.
REQ-014 On line_start in any state, SHALL latch next_y, clear the list, set seg index to 0, and enter SCAN; this includes mid-SCAN, which restarts the scan.
REQ-015 In SCAN, SHALL test one segment per cycle for i = 0 .. min(length,23)-1: overlap when next_y >= y_i and next_y < y_i+32, compared at 12 bits so there is no wrap.
REQ-016 On overlap, SHALL append {x_i, row = next_y - y_i (5 bits), is_head = (i == 0)} to the next free slot of an 8-entry list.
REQ-017 On overlap with the list full, SHALL drop the entry and set ovf; ovf clears on the next line_start.
REQ-018 After the last segment, SHALL enter READY and pulse scan_done for one cycle, so latency is min(length,23)+1 cycles after line_start.
REQ-019 With length = 0, SHALL go from SCAN to READY in one cycle with an empty list.
REQ-020 With length > 23, SHALL clamp to 23.
REQ-021 In READY, SHALL compare curr_x against every valid entry in parallel (x_e <= curr_x < x_e+32, 12-bit compare); the lowest slot wins.
REQ-022 SHALL register outputs with one-cycle latency: hit, hit_head, and sprite_addr = (curr_x - x_e) + row*32 for the winner.
REQ-023 In IDLE or SCAN, and on no match, SHALL drive hit = 0, hit_head = 0 and sprite_addr = 0.
REQ-024 SHALL ignore changes to snakepos, next_y and length while in READY until the next line_start.

Reset
REQ-025 While rst = 0 at a clk edge, SHALL enter IDLE, invalidate all entries, and drive scan_done, hit, hit_head, sprite_addr and ovf to 0.
REQ-026 Reset mid-SCAN SHALL abort the scan, and no scan_done SHALL follow.

Configuration
REQ-027 With macro SEG_SCHED_OVF_EN defined, SHALL implement ovf per REQ-017.
REQ-028 Without SEG_SCHED_OVF_EN, ovf SHALL be tied to 0, no overflow logic SHALL exist, and excess overlaps SHALL still be dropped silently.

Structure
REQ-029 Package snake_gfx_pkg SHALL hold BLK_SIZE = 32, MAX_SEGMENTS = 23, LIST_DEPTH = 8, COORD_W = 11, the FSM state enum, and the list-entry typedef.
REQ-030 The per-entry range comparator SHALL be sub-module seg_hit_cmp, instantiated LIST_DEPTH times.

Verification
REQ-031 length = 3; segments (100,200), (68,200), (36,200); next_y = 215 -> scan_done 4 cycles after line_start; curr_x = 110 -> hit = 1, hit_head = 1, sprite_addr = 10+15*32 = 490.
REQ-032 Same setup, curr_x = 70 -> hit = 1, hit_head = 0, sprite_addr = 482; curr_x = 140 -> hit = 0.
REQ-033 next_y = 232, all y = 200 -> empty list; any curr_x -> hit = 0 (upper boundary exclusive).
REQ-034 length = 10, all y = 0, next_y = 5 -> 8 entries, ovf = 1 with the macro defined and ovf = 0 without it; the next line_start clears ovf.
REQ-035 length = 0 -> scan_done 1 cycle after line_start; line_start re-issued mid-SCAN -> the scan restarts and exactly one scan_done follows.
REQ-036 rst = 0 asserted during SCAN -> all outputs 0, state IDLE, and no scan_done.

Source files
------------

// File: rtl/snake_gfx_pkg.sv
// Shared constants, FSM state and list-entry types for the snake line scheduler.
// Overflow flagging is enabled by defining SEG_SCHED_OVF_EN.
package snake_gfx_pkg;

    localparam int unsigned BLK_SIZE     = 32;
    localparam int unsigned MAX_SEGMENTS = 23;
    localparam int unsigned LIST_DEPTH   = 8;
    localparam int unsigned COORD_W      = 11;

    localparam int unsigned CMP_W  = COORD_W + 1;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = 2 * ROW_W;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned CNT_W  = SLOT_W + 1;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned POS_W  = MAX_SEGMENTS * COORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        READY = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [ROW_W-1:0]   row;
        logic               is_head;
    } list_entry_t;

    // pos lies in [base, base+BLK_SIZE); widened by one bit so base+32 cannot wrap
    function automatic logic in_block(input logic [COORD_W-1:0] pos,
                                      input logic [COORD_W-1:0] base);
        logic [CMP_W-1:0] p;
        logic [CMP_W-1:0] b;
        p = CMP_W'(pos);
        b = CMP_W'(base);
        return (p >= b) && (p < (b + CMP_W'(BLK_SIZE)));
    endfunction

endpackage

// File: rtl/seg_hit_cmp.sv
// Range comparator for one list entry: does the queried column fall inside its block?
import snake_gfx_pkg::*;

module seg_hit_cmp (
    input  logic               valid,
    input  logic [COORD_W-1:0] base,
    input  logic [COORD_W-1:0] query,
    output logic               match_c,
    output logic [ROW_W-1:0]   offset_c
);

    logic [COORD_W-1:0] diff;

    assign diff     = query - base;
    assign match_c  = valid & in_block(query, base);
    assign offset_c = diff[ROW_W-1:0];

endmodule

// File: rtl/seg_line_sched.sv
// Per-line snake segment scheduler: scans segments during blanking into a short list,
// then answers per-pixel hit/sprite queries. Define SEG_SCHED_OVF_EN for the ovf flag.
import snake_gfx_pkg::*;

module seg_line_sched (
    input  logic                clk,
    input  logic                rst,
    input  logic                line_start,
    input  logic [COORD_W-1:0]  next_y,
    input  logic [POS_W-1:0]    snakepos_x,
    input  logic [POS_W-1:0]    snakepos_y,
    input  logic [LEN_W-1:0]    length,
    input  logic [COORD_W-1:0]  curr_x,
    output logic                scan_done,
    output logic                hit,
    output logic                hit_head,
    output logic [ADDR_W-1:0]   sprite_addr,
    output logic                ovf
);

    sched_state_t       state;
    list_entry_t        list_q [LIST_DEPTH];
    logic [COORD_W-1:0] ny_q;
    logic [IDX_W-1:0]   len_q;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic [COORD_W-1:0] pos_x [MAX_SEGMENTS];
    logic [COORD_W-1:0] pos_y [MAX_SEGMENTS];
    logic [IDX_W-1:0]   len_clamp;
    logic [COORD_W-1:0] seg_x;
    logic [COORD_W-1:0] seg_y;
    logic [COORD_W-1:0] row_diff;
    logic               overlap;

    logic               match [LIST_DEPTH];
    logic [ROW_W-1:0]   offset [LIST_DEPTH];
    logic               win_hit;
    logic               win_head;
    logic [ADDR_W-1:0]  win_addr;

    for (genvar g = 0; g < MAX_SEGMENTS; g++) begin : g_unpack
        assign pos_x[g] = snakepos_x[g*COORD_W +: COORD_W];
        assign pos_y[g] = snakepos_y[g*COORD_W +: COORD_W];
    end

    assign len_clamp = (length > LEN_W'(MAX_SEGMENTS)) ? IDX_W'(MAX_SEGMENTS) : IDX_W'(length);

    // Segment currently under test; idx never reaches MAX_SEGMENTS while testing
    always_comb begin
        seg_x = '0;
        seg_y = '0;
        if (idx < IDX_W'(MAX_SEGMENTS)) begin
            seg_x = pos_x[idx];
            seg_y = pos_y[idx];
        end
    end

    assign overlap  = in_block(ny_q, seg_y);
    assign row_diff = ny_q - seg_y;

    for (genvar e = 0; e < LIST_DEPTH; e++) begin : g_cmp
        seg_hit_cmp u_cmp (
            .valid    (list_q[e].valid),
            .base     (list_q[e].x),
            .query    (curr_x),
            .match_c  (match[e]),
            .offset_c (offset[e])
        );
    end

    // Priority select: descending walk lets the lowest matching slot win
    always_comb begin
        win_hit  = 1'b0;
        win_head = 1'b0;
        win_addr = '0;
        for (int e = LIST_DEPTH - 1; e >= 0; e--) begin
            if (match[e]) begin
                win_hit  = 1'b1;
                win_head = list_q[e].is_head;
                win_addr = {list_q[e].row, offset[e]};
            end
        end
    end

`ifdef SEG_SCHED_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ny_q        <= '0;
            len_q       <= '0;
            idx         <= '0;
            cnt         <= '0;
            scan_done   <= 1'b0;
            hit         <= 1'b0;
            hit_head    <= 1'b0;
            sprite_addr <= '0;
            for (int e = 0; e < LIST_DEPTH; e++) list_q[e] <= '0;
`ifdef SEG_SCHED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            scan_done   <= 1'b0;
            hit         <= 1'b0;
            hit_head    <= 1'b0;
            sprite_addr <= '0;
            if (line_start) begin
                state <= SCAN;
                ny_q  <= next_y;
                len_q <= len_clamp;
                idx   <= '0;
                cnt   <= '0;
                for (int e = 0; e < LIST_DEPTH; e++) list_q[e].valid <= 1'b0;
`ifdef SEG_SCHED_OVF_EN
                ovf_q <= 1'b0;
`endif
            end else begin
                case (state)
                    SCAN: begin
                        if (idx == len_q) begin
                            state     <= READY;
                            scan_done <= 1'b1;
                        end else begin
                            if (overlap) begin
                                if (cnt < CNT_W'(LIST_DEPTH)) begin
                                    list_q[cnt[SLOT_W-1:0]] <= '{valid:   1'b1,
                                                                x:       seg_x,
                                                                row:     row_diff[ROW_W-1:0],
                                                                is_head: (idx == '0)};
                                    cnt <= cnt + CNT_W'(1);
                                end else begin
`ifdef SEG_SCHED_OVF_EN
                                    ovf_q <= 1'b1;
`else
                                    cnt <= cnt;
`endif
                                end
                            end
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    READY: begin
                        hit         <= win_hit;
                        hit_head    <= win_head;
                        sprite_addr <= win_addr;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
